// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit RISC datapath: fetch/decode/execute/memory/writeback
// with a memory-ready timeout. Define MULTICYCLE_SEQ_PERF_EN to add instr_count/stall_count.
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_w,
    output logic [1:0]  pc_src,
    output logic        ir_w,
    output logic        i_or_d,
    output logic        mem_r,
    output logic        mem_w,
    output logic        reg_w,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        retire,
    output logic        fault,
    output logic [3:0]  state
`ifdef MULTICYCLE_SEQ_PERF_EN
    ,
    output logic [15:0] instr_count,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        EXEC     = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        FAULT    = 4'd11
    } state_e;

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_SW  = 4'd1;
    localparam logic [3:0] OP_BEQ = 4'd12;
    localparam logic [3:0] OP_BNE = 4'd13;
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);
    localparam bit         TIMEOUT_EN  = (TIMEOUT != 0);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       mem_wait;

    always_comb begin
        // NOTE: every variable gets a default up front so no branch of the case can infer a latch.
        state_d    = state_q;
        pc_w       = 1'b0;
        pc_src     = 2'b00;
        ir_w       = 1'b0;
        i_or_d     = 1'b0;
        mem_r      = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;
        mem_wait   = 1'b0;

        case (state_q)
            IDLE: if (run) state_d = FETCH;
            FETCH: begin
                mem_r     = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                if (mem_ready) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    state_d = DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b10;
                if (opcode == OP_LW || opcode == OP_SW)        state_d = MEM_ADDR;
                else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = BRANCH;
                else if (opcode >= 4'd14)                      state_d = JUMP;
                else                                           state_d = EXEC;
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                state_d   = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_r  = 1'b1;
                i_or_d = 1'b1;
                if (mem_ready) state_d = MEM_WB;
                else           mem_wait = 1'b1;
            end
            MEM_WB: begin
                reg_w      = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            MEM_WR: begin
                mem_w  = 1'b1;
                i_or_d = 1'b1;
                if (mem_ready) retire   = 1'b1;
                else           mem_wait = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_w   = 1'b1;
                reg_dst = 1'b1;
                retire  = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                retire    = 1'b1;
                pc_w      = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
            end
            JUMP: begin
                pc_w   = 1'b1;
                pc_src = 2'b10;
                retire = 1'b1;
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        if (retire) state_d = run ? FETCH : IDLE;

        // The TIMEOUT-th consecutive wait cycle traps; a ready in that cycle is not a wait, so it wins.
        if (TIMEOUT_EN && mem_wait && (({1'b0, wait_q} + 9'd1) == TIMEOUT_LIM)) state_d = FAULT;

        wait_d = mem_wait ? wait_q + 8'd1 : 8'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign fault = (state_q == FAULT);
    assign state = state_q;

`ifdef MULTICYCLE_SEQ_PERF_EN
    logic [15:0] instr_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (retire) instr_cnt_q <= instr_cnt_q + 16'd1;
            if (mem_wait && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign instr_count = instr_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: a driver issues instructions with random memory waits
// and queues each instruction's expected phase trace; a monitor checks the DUT against it every cycle.
module tb_multicycle_sequencer;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_EXEC = 4'd7;
    localparam logic [3:0] S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_FAULT = 4'd11;

    logic        clk, rst_n, run, zero, mem_ready;
    logic [3:0]  opcode;
    logic        pc_w, ir_w, i_or_d, mem_r, mem_w, reg_w, reg_dst, mem_to_reg, alu_src_a;
    logic        retire, fault;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic [3:0]  state;
`ifdef MULTICYCLE_SEQ_PERF_EN
    logic [15:0] instr_count, stall_count;
`endif

    multicycle_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_w(pc_w), .pc_src(pc_src), .ir_w(ir_w), .i_or_d(i_or_d), .mem_r(mem_r), .mem_w(mem_w),
        .reg_w(reg_w), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .retire(retire), .fault(fault), .state(state)
`ifdef MULTICYCLE_SEQ_PERF_EN
        , .instr_count(instr_count), .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] ctl;
    logic [11:0] act_word;
    assign ctl = {pc_w, pc_src, ir_w, i_or_d, mem_r, mem_w, reg_w, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, retire, fault};
    assign act_word = {pc_src, reg_dst, mem_to_reg, i_or_d, mem_r, mem_w, alu_src_a, alu_src_b, alu_op};

    typedef struct {
        logic [3:0] trace [16];
        int         len;
        int         pcw_cnt;
        int         regw_cnt;
        logic       ret_pcw;
        logic       ret_regw;
        logic [3:0] next_st;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Steady datapath-select word each phase presents:
    // {pc_src, reg_dst, mem_to_reg, i_or_d, mem_r, mem_w, alu_src_a, alu_src_b, alu_op}
    function automatic logic [11:0] exp_word(input logic [3:0] st);
        case (st)
            S_FETCH:    return 12'b00_0_0_0_1_0_0_01_10;
            S_DECODE:   return 12'b00_0_0_0_0_0_0_11_10;
            S_MEM_ADDR: return 12'b00_0_0_0_0_0_1_10_10;
            S_MEM_RD:   return 12'b00_0_0_1_1_0_0_00_00;
            S_MEM_WB:   return 12'b00_0_1_0_0_0_0_00_00;
            S_MEM_WR:   return 12'b00_0_0_1_0_1_0_00_00;
            S_EXEC:     return 12'b00_0_0_0_0_0_1_00_00;
            S_ALU_WB:   return 12'b00_1_0_0_0_0_0_00_00;
            S_BRANCH:   return 12'b01_0_0_0_0_0_1_00_01;
            S_JUMP:     return 12'b10_0_0_0_0_0_0_00_00;
            default:    return 12'b0;
        endcase
    endfunction

    // Instruction-level model: phase sequence by opcode class, plus write-enable expectations.
    function automatic exp_t model(input logic [3:0] op, input logic z, input int wf, input int wm,
                                   input logic run_after);
        exp_t e;
        logic taken;
        e.len = 0;
        e.regw_cnt = 0;
        taken = 1'b0;
        for (int i = 0; i <= wf; i++) e.trace[e.len++] = S_FETCH;
        e.trace[e.len++] = S_DECODE;
        if (op == 4'd0) begin
            e.trace[e.len++] = S_MEM_ADDR;
            for (int i = 0; i <= wm; i++) e.trace[e.len++] = S_MEM_RD;
            e.trace[e.len++] = S_MEM_WB;
            e.regw_cnt = 1;
        end else if (op == 4'd1) begin
            e.trace[e.len++] = S_MEM_ADDR;
            for (int i = 0; i <= wm; i++) e.trace[e.len++] = S_MEM_WR;
        end else if (op <= 4'd11) begin
            e.trace[e.len++] = S_EXEC;
            e.trace[e.len++] = S_ALU_WB;
            e.regw_cnt = 1;
        end else if (op <= 4'd13) begin
            e.trace[e.len++] = S_BRANCH;
            taken = (op == 4'd12) ? z : !z;
        end else begin
            e.trace[e.len++] = S_JUMP;
            taken = 1'b1;
        end
        e.pcw_cnt  = taken ? 2 : 1;
        e.ret_pcw  = taken;
        e.ret_regw = (e.regw_cnt == 1);
        e.next_st  = run_after ? S_FETCH : S_IDLE;
        return e;
    endfunction

    // Monitor: walks the front scoreboard entry one phase per cycle.
    int         idx = 0, irw_seen = 0, pcw_seen = 0, regw_seen = 0;
    bit         pend_next = 1'b0;
    logic [3:0] pend_state;
    exp_t       cur;

    always begin
        @(negedge clk);
        #3;
        if (mon_en) begin
            if (pend_next) begin
                check("next_state", 32'(state), 32'(pend_state));
                pend_next = 1'b0;
            end
            check("mem_rw_excl", 32'(mem_r & mem_w), 32'd0);
            if (state == S_IDLE) begin
                check("idle_quiet", 32'({reg_w, pc_w}), 32'd0);
            end else if (sb_q.size() == 0) begin
                check("unexpected_active", 32'(state), 32'(S_IDLE));
            end else begin
                cur = sb_q[0];
                if (idx >= cur.len) begin
                    check("overrun", 32'(idx), 32'(cur.len - 1));
                    void'(sb_q.pop_front());
                    idx = 0; irw_seen = 0; pcw_seen = 0; regw_seen = 0;
                end else begin
                    check("state", 32'(state), 32'(cur.trace[idx]));
                    check("ctl_word", 32'(act_word), 32'(exp_word(cur.trace[idx])));
                    irw_seen  += int'(ir_w);
                    pcw_seen  += int'(pc_w);
                    regw_seen += int'(reg_w);
                    if (retire) begin
                        check("latency", 32'(idx + 1), 32'(cur.len));
                        check("ret_reg_w", 32'(reg_w), 32'(cur.ret_regw));
                        check("ret_pc_w", 32'(pc_w), 32'(cur.ret_pcw));
                        check("ir_w_count", 32'(irw_seen), 32'd1);
                        check("pc_w_count", 32'(pcw_seen), 32'(cur.pcw_cnt));
                        check("reg_w_count", 32'(regw_seen), 32'(cur.regw_cnt));
                        pend_next  = 1'b1;
                        pend_state = cur.next_st;
                        void'(sb_q.pop_front());
                        idx = 0; irw_seen = 0; pcw_seen = 0; regw_seen = 0;
                    end else begin
                        idx++;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = 4'd0;
        zero      = 1'b0;
        repeat (2) @(negedge clk);
        sb_q.delete();
        idx = 0; irw_seen = 0; pcw_seen = 0; regw_seen = 0;
        pend_next = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Driver: answers each memory access after its planned number of wait cycles.
    task automatic run_instr(input logic [3:0] op, input logic z, input int wf, input int wm,
                             input logic run_after);
        int access = 0;
        int waited = 0;
        int lim;
        bit done = 1'b0;
        sb_q.push_back(model(op, z, wf, wm, run_after));
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            #1;
            opcode = op;
            zero   = z;
            run    = (state == S_IDLE) ? 1'b1 : run_after;
            if (mem_r || mem_w) begin
                lim = (access == 0) ? wf : wm;
                if (waited == lim) begin
                    mem_ready = 1'b1;
                    access++;
                    waited = 0;
                end else begin
                    mem_ready = 1'b0;
                    waited++;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            done = retire;
        end
        if (!done) check("retire_timeout", 32'd0, 32'd1);
    endtask

    task automatic timeout_test();
        int n = 0;
        do_reset();
        #1;
        run = 1'b1;
        mem_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (state == S_FAULT) break;
            if (state == S_FETCH) n++;
        end
        check("timeout_wait_cycles", 32'(n), 32'd4);
        check("fault_state", 32'(state), 32'(S_FAULT));
        mem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("fault_sticky_state", 32'(state), 32'(S_FAULT));
            check("fault_ctl", 32'(ctl), 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check("fault_reset_state", 32'(state), 32'(S_IDLE));
        check("fault_reset_flag", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic async_reset_test();
        bit found = 1'b0;
        do_reset();
        #1;
        run = 1'b1;
        opcode = 4'd1;
        mem_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            #1;
            if (state == S_MEM_WR) found = 1'b1;
        end
        check("reach_mem_wr", 32'(state), 32'(S_MEM_WR));
        mem_ready = 1'b0;
        #1;
        check("mem_wr_asserted", 32'(mem_w), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_ctl", 32'(ctl), 32'd0);
        check("async_reset_state", 32'(state), 32'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op;
        logic       z, ra;
        int         wf, wm;

        rst_n = 1'b0; run = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
        do_reset();
        #1;
        check("reset_state", 32'(state), 32'(S_IDLE));
        check("reset_ctl", 32'(ctl), 32'd0);
`ifdef MULTICYCLE_SEQ_PERF_EN
        check("reset_instr_count", 32'(instr_count), 32'd0);
        check("reset_stall_count", 32'(stall_count), 32'd0);
`endif
        mon_en = 1'b1;

        // Three instructions with two wait cycles in total, ending in IDLE.
        run_instr(4'd3, 1'b0, 1, 0, 1'b1);
        run_instr(4'd0, 1'b0, 0, 1, 1'b1);
        run_instr(4'd14, 1'b0, 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
`ifdef MULTICYCLE_SEQ_PERF_EN
        check("perf_instr_count", 32'(instr_count), 32'd3);
        check("perf_stall_count", 32'(stall_count), 32'd2);
`endif

        run_instr(4'd3, 1'b0, 0, 0, 1'b1);
        run_instr(4'd0, 1'b0, 0, 2, 1'b1);
        run_instr(4'd12, 1'b1, 0, 0, 1'b1);
        run_instr(4'd13, 1'b1, 0, 0, 1'b1);
        run_instr(4'd1, 1'b0, 2, 3, 1'b1);
        run_instr(4'd0, 1'b0, 3, 3, 1'b1);
        run_instr(4'd14, 1'b0, 0, 0, 1'b0);
        run_instr(4'd15, 1'b0, 0, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            z  = 1'($urandom_range(0, 1));
            wf = int'($urandom_range(0, 3));
            wm = int'($urandom_range(0, 3));
            ra = (i == 39) ? 1'b0 : ($urandom_range(0, 4) != 0);
            run_instr(op, z, wf, wm, ra);
        end

        repeat (3) @(negedge clk);
        #4;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        timeout_test();
        async_reset_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit RISC datapath, driven by the 4-bit opcode held in the instruction register.
- Sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Waits on a memory ready handshake, with a timeout that traps to a fault state.
- Sits between the instruction register/flags and the datapath mux/write-enable controls.

Parameters:
- TIMEOUT, 16: max consecutive wait cycles in any memory state before fault; 0 disables timeout; legal range 0..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  start/continue execution; sampled in IDLE and at instruction retirement.
- opcode  in  4  IR[15:12], valid from DECODE onward.
- zero  in  1  ALU zero flag, combinational from the current ALU operation.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_w  out  1  PC write enable.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target.
- ir_w  out  1  IR write enable.
- i_or_d  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_r  out  1  memory read request.
- mem_w  out  1  memory write request.
- reg_w  out  1  register file write enable.
- reg_dst  out  1  write register select: 1 rd, 0 rt.
- mem_to_reg  out  1  writeback source: 1 MDR, 0 ALUOut.
- alu_src_a  out  1  ALU A input: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B input: 00 rt, 01 constant 1, 10 sext(imm), 11 sext(imm) branch offset.
- alu_op  out  2  10 add, 01 subtract, 00 function from opcode.
- retire  out  1  one-cycle pulse in an instruction's final cycle.
- fault  out  1  sticky memory-timeout flag.
- state  out  4  current state encoding, for debug.

Behaviour:
- Opcode classes:
  - 0 = LW.
  - 1 = SW.
  - 2..11 = ALU (R-type).
  - 12 = BEQ.
  - 13 = BNE.
  - 14, 15 = J.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC=7, ALU_WB=8, BRANCH=9, JUMP=10, FAULT=11.
- Reset (async, rst_n=0): state=IDLE, fault=0, wait counter=0. Every control output is 0 in IDLE/reset.
- IDLE: go to FETCH when run=1.
- FETCH: mem_r=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=10.
  - ir_w and pc_w (pc_src=00) assert only in the cycle mem_ready=1; that same cycle, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=10 (branch target into ALUOut). Next state by opcode:
  - LW/SW → MEM_ADDR.
  - ALU → EXEC.
  - BEQ/BNE → BRANCH.
  - J → JUMP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=10. Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_r=1, i_or_d=1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_w=1, reg_dst=0, mem_to_reg=1, retire=1.
- MEM_WR: mem_w=1, i_or_d=1. On mem_ready: retire=1, then retirement transition.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=00.
- ALU_WB: reg_w=1, reg_dst=1, mem_to_reg=0, retire=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, retire=1.
  - pc_w = (opcode==12 & zero) | (opcode==13 & ~zero).
- JUMP: pc_w=1, pc_src=10, retire=1.
- Retirement transition: FETCH if run=1, else IDLE. A run drop mid-instruction has no effect until retirement.
- Latency with mem_ready tied high:
  - ALU 4 cycles.
  - LW 5 cycles.
  - SW 4 cycles.
  - BEQ/BNE 3 cycles.
  - J 3 cycles.
- Each wait cycle adds 1 cycle.
- Wait counter (8-bit):
  - Increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0.
  - Clears on mem_ready=1 or on leaving the state.
- Timeout: if TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ready still 0, go to FAULT next cycle.
  - A mem_ready arriving in the same cycle the counter hits TIMEOUT wins; no fault.
- FAULT: fault=1, all other controls 0, remains until reset.
- mem_r and mem_w are never both 1. reg_w and pc_w never assert in FAULT or IDLE.

Optional Feature:
- Macro: MULTICYCLE_SEQ_PERF_EN.
- When defined:
  - Adds output instr_count (16 bits): increments on every retire pulse, wraps 0xFFFF→0x0000, resets to 0.
  - Adds output stall_count (16 bits): increments on every memory wait cycle, saturates at 0xFFFF, resets to 0.
- When undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then run=1 with mem_ready=1 and opcode=3 → states 1,2,7,8 in order; reg_w=1, reg_dst=1 in ALU_WB; retire pulses once; back to FETCH.
- opcode=0 with mem_ready low 2 cycles in MEM_RD → LW takes 7 cycles; ir_w exactly once; mem_to_reg=1 with reg_w=1 in MEM_WB.
- opcode=12 with zero=1 → pc_w=1, pc_src=01 in BRANCH. opcode=13 with zero=1 → pc_w=0; both take 3 cycles.
- TIMEOUT=4, mem_ready held 0 in FETCH → FAULT entered after 4 wait cycles; fault=1 sticky; rst_n=0 returns to IDLE with fault=0.
- Assert rst_n=0 mid-MEM_WR → all outputs 0 immediately, without waiting for a clock edge. run=0 at retirement of opcode=14 → IDLE; reasserting run=1 → FETCH.
- With MULTICYCLE_SEQ_PERF_EN: run 3 instructions with 2 total wait cycles → instr_count=3, stall_count=2.
